sdram_bus_bridge: RTL and testbench



---
 rtl/sdram_bus_bridge.sv | 192 +++++++++++++++++++
 tb/tb_sdram_bus_bridge.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_bus_bridge.sv
// sdram_bus_bridge: splits each 32-bit PicoRV32 native-bus access into 32/MEM_W sdram_controller beats.
// Optional macro SDRAM_BUS_BRIDGE_RMW_EN: partial-strobe write beats become read-merge-write.
module sdram_bus_bridge #(
  parameter int MEM_W     = 16,
  parameter int SD_ADDR_W = 22
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 bus_valid,
  input  logic [31:0]          bus_addr,
  input  logic [31:0]          bus_wdata,
  input  logic [3:0]           bus_wstrb,
  output logic                 bus_ready,
  output logic [31:0]          bus_rdata,
  output logic [SD_ADDR_W-1:0] sd_wr_addr,
  output logic [MEM_W-1:0]     sd_wr_data,
  output logic                 sd_wr_enable,
  output logic [SD_ADDR_W-1:0] sd_rd_addr,
  output logic                 sd_rd_enable,
  input  logic [MEM_W-1:0]     sd_rd_data,
  input  logic                 sd_rd_ready,
  input  logic                 sd_busy
);

  localparam int BEATS = 32 / MEM_W;
  localparam int SB    = MEM_W / 8;
  localparam int SHIFT = (MEM_W == 8) ? 0 : (MEM_W == 16) ? 1 : 2;

`ifdef SDRAM_BUS_BRIDGE_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    REQ,
    WAIT,
    DONE
  } state_t;

  state_t               state_q, state_d;
  logic [1:0]           beat_q, beat_d;
  logic [SD_ADDR_W-1:0] base_q, base_d;
  logic [31:0]          wdata_q, wdata_d;
  logic [3:0]           wstrb_q, wstrb_d;
  logic                 is_write_q, is_write_d;
  logic                 req_rd_q, req_rd_d;
  logic                 rmw_done_q, rmw_done_d;
  logic [MEM_W-1:0]     wr_data_q, wr_data_d;
  logic [31:0]          asm_q, asm_d;
  logic [31:0]          rdata_q, rdata_d;

  logic [SB-1:0]        strb_slice;
  logic [MEM_W-1:0]     wr_lane;
  logic                 last_beat;
  logic                 need_rmw;

  assign strb_slice = wstrb_q[32'(beat_q) * SB +: SB];
  assign wr_lane    = wdata_q[32'(beat_q) * MEM_W +: MEM_W];
  assign last_beat  = (beat_q == 2'(BEATS - 1));
  // A partial beat needs its old contents fetched once before the merged write.
  assign need_rmw   = RMW_EN && (strb_slice != '0) && (strb_slice != '1) && !rmw_done_q;

  assign bus_ready    = (state_q == DONE);
  assign bus_rdata    = rdata_q;
  assign sd_wr_addr   = base_q + SD_ADDR_W'(beat_q);
  assign sd_rd_addr   = base_q + SD_ADDR_W'(beat_q);
  assign sd_wr_data   = wr_data_q;
  assign sd_rd_enable = (state_q == REQ) && req_rd_q;
  assign sd_wr_enable = (state_q == REQ) && !req_rd_q;

  always_comb begin
    state_d    = state_q;
    beat_d     = beat_q;
    base_d     = base_q;
    wdata_d    = wdata_q;
    wstrb_d    = wstrb_q;
    is_write_d = is_write_q;
    req_rd_d   = req_rd_q;
    rmw_done_d = rmw_done_q;
    wr_data_d  = wr_data_q;
    asm_d      = asm_q;
    rdata_d    = rdata_q;

    unique case (state_q)
      IDLE: begin
        if (bus_valid && !bus_ready) begin
          base_d     = SD_ADDR_W'(bus_addr >> SHIFT);
          wdata_d    = bus_wdata;
          wstrb_d    = bus_wstrb;
          is_write_d = |bus_wstrb;
          beat_d     = '0;
          rmw_done_d = 1'b0;
          state_d    = ARM;
        end
      end

      ARM: begin
        if (is_write_q && strb_slice == '0) begin
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else if (!sd_busy) begin
          req_rd_d = !is_write_q || need_rmw;
          if (is_write_q && !rmw_done_q) begin
            wr_data_d = wr_lane;
          end
          state_d = REQ;
        end
      end

      REQ: begin
        if (sd_busy) begin
          state_d = WAIT;
        end
      end

      WAIT: begin
        if (req_rd_q) begin
          if (sd_rd_ready) begin
            if (is_write_q) begin
              // Merge read-back bytes under the strobes, then return to ARM for the write.
              for (int i = 0; i < SB; i++) begin
                wr_data_d[i*8 +: 8] = strb_slice[i] ? wr_lane[i*8 +: 8] : sd_rd_data[i*8 +: 8];
              end
              rmw_done_d = 1'b1;
              state_d    = ARM;
            end else begin
              asm_d[32'(beat_q) * MEM_W +: MEM_W] = sd_rd_data;
              if (last_beat) begin
                rdata_d = asm_d;
                state_d = DONE;
              end else begin
                beat_d  = beat_q + 2'd1;
                state_d = ARM;
              end
            end
          end
        end else if (!sd_busy) begin
          rmw_done_d = 1'b0;
          if (last_beat) begin
            state_d = DONE;
          end else begin
            beat_d  = beat_q + 2'd1;
            state_d = ARM;
          end
        end
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q    <= IDLE;
      beat_q     <= '0;
      base_q     <= '0;
      wdata_q    <= '0;
      wstrb_q    <= '0;
      is_write_q <= 1'b0;
      req_rd_q   <= 1'b0;
      rmw_done_q <= 1'b0;
      wr_data_q  <= '0;
      asm_q      <= '0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      beat_q     <= beat_d;
      base_q     <= base_d;
      wdata_q    <= wdata_d;
      wstrb_q    <= wstrb_d;
      is_write_q <= is_write_d;
      req_rd_q   <= req_rd_d;
      rmw_done_q <= rmw_done_d;
      wr_data_q  <= wr_data_d;
      asm_q      <= asm_d;
      rdata_q    <= rdata_d;
    end
  end

endmodule

// File: tb/tb_sdram_bus_bridge.sv
// Testbench for sdram_bus_bridge (MEM_W=16): directed plan steps plus randomized ops
// against a word-level reference model; honours SDRAM_BUS_BRIDGE_RMW_EN when defined.
module tb_sdram_bus_bridge;

  localparam int MEM_W     = 16;
  localparam int SD_ADDR_W = 22;
  localparam int LAT       = 3;

`ifdef SDRAM_BUS_BRIDGE_RMW_EN
  localparam bit RMW_EN = 1'b1;
`else
  localparam bit RMW_EN = 1'b0;
`endif

  logic                 clk = 1'b0;
  logic                 resetn = 1'b0;
  logic                 bus_valid = 1'b0;
  logic [31:0]          bus_addr = '0;
  logic [31:0]          bus_wdata = '0;
  logic [3:0]           bus_wstrb = '0;
  logic                 bus_ready;
  logic [31:0]          bus_rdata;
  logic [SD_ADDR_W-1:0] sd_wr_addr;
  logic [MEM_W-1:0]     sd_wr_data;
  logic                 sd_wr_enable;
  logic [SD_ADDR_W-1:0] sd_rd_addr;
  logic                 sd_rd_enable;
  logic [MEM_W-1:0]     sd_rd_data = '0;
  logic                 sd_rd_ready = 1'b0;
  logic                 sd_busy;

  int checks = 0;
  int errors = 0;

  sdram_bus_bridge #(.MEM_W(MEM_W), .SD_ADDR_W(SD_ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .bus_valid(bus_valid), .bus_addr(bus_addr), .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb),
    .bus_ready(bus_ready), .bus_rdata(bus_rdata),
    .sd_wr_addr(sd_wr_addr), .sd_wr_data(sd_wr_data), .sd_wr_enable(sd_wr_enable),
    .sd_rd_addr(sd_rd_addr), .sd_rd_enable(sd_rd_enable),
    .sd_rd_data(sd_rd_data), .sd_rd_ready(sd_rd_ready), .sd_busy(sd_busy)
  );

  always #5 clk = ~clk;

  // Controller stand-in: acts on the falling edge so its responses are stable at the DUT's rising edge.
  logic [15:0] mem [0:1023];
  logic [15:0] ref_mem [0:1023];
  logic [47:0] acc_q[$];
  logic        ctl_busy = 1'b0;
  logic        ctl_rd = 1'b0;
  logic [15:0] ctl_data = '0;
  int          ctl_cnt = 0;
  logic        force_busy = 1'b0;
  int          both_cnt = 0;

  assign sd_busy = ctl_busy | force_busy;

  function automatic logic [47:0] pack(input bit wr, input logic [21:0] a, input logic [15:0] d);
    return {7'b0, wr, 2'b0, a, d};
  endfunction

  function automatic int idx(input logic [21:0] a);
    return int'(a[9:0]);
  endfunction

  always @(negedge clk) begin
    sd_rd_ready <= 1'b0;
    if (sd_rd_enable && sd_wr_enable) both_cnt++;
    if (ctl_cnt != 0) begin
      ctl_cnt <= ctl_cnt - 1;
      if (ctl_cnt == 1) begin
        ctl_busy <= 1'b0;
        if (ctl_rd) begin
          sd_rd_ready <= 1'b1;
          sd_rd_data  <= ctl_data;
        end
      end
    end else if (!sd_busy && (sd_rd_enable || sd_wr_enable)) begin
      if (sd_wr_enable) begin
        mem[idx(sd_wr_addr)] = sd_wr_data;
        acc_q.push_back(pack(1'b1, sd_wr_addr, sd_wr_data));
        ctl_rd <= 1'b0;
      end else begin
        ctl_data <= mem[idx(sd_rd_addr)];
        acc_q.push_back(pack(1'b0, sd_rd_addr, mem[idx(sd_rd_addr)]));
        ctl_rd <= 1'b1;
      end
      ctl_busy <= 1'b1;
      ctl_cnt  <= LAT;
    end
  end

  // Results of the most recent applyStimulus call.
  int          pulses, en_forced, first_en;
  logic [31:0] got_rdata;
  logic [47:0] exp_q[$];
  logic [31:0] exp_rdata;
  logic [31:0] last_rdata = '0;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  function automatic logic [47:0] accAt(input int i);
    if (i < acc_q.size()) return acc_q[i];
    return 48'hFFFF_FFFF_FFFF;
  endfunction

  task automatic preload(input int a, input logic [15:0] d);
    mem[a]     = d;
    ref_mem[a] = d;
  endtask

  // Word-level reference: what a 32-bit access means as a list of 16-bit memory accesses.
  task automatic modelOp(input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] wstrb);
    logic [21:0] base;
    logic [1:0]  s;
    logic [15:0] lane, old, nw;
    base = 22'((addr >> 1) & 32'h3F_FFFF);
    exp_q.delete();
    if (wstrb == 4'b0000) begin
      for (int b = 0; b < 2; b++) exp_q.push_back(pack(1'b0, base + 22'(b), ref_mem[idx(base + 22'(b))]));
      exp_rdata = {ref_mem[idx(base + 22'd1)], ref_mem[idx(base)]};
    end else begin
      exp_rdata = last_rdata;
      for (int b = 0; b < 2; b++) begin
        s    = wstrb[2*b +: 2];
        lane = wdata[16*b +: 16];
        old  = ref_mem[idx(base + 22'(b))];
        if (s != 2'b00) begin
          nw = lane;
          if (RMW_EN && s != 2'b11) begin
            exp_q.push_back(pack(1'b0, base + 22'(b), old));
            nw = old;
            if (s[0]) nw[7:0] = lane[7:0];
            if (s[1]) nw[15:8] = lane[15:8];
          end
          exp_q.push_back(pack(1'b1, base + 22'(b), nw));
          ref_mem[idx(base + 22'(b))] = nw;
        end
      end
    end
  endtask

  task automatic applyStimulus(input logic [31:0] addr, input logic [31:0] wdata,
                               input logic [3:0] wstrb, input int hold);
    bit seen;
    acc_q.delete();
    pulses = 0; en_forced = 0; first_en = -1; got_rdata = '0; seen = 1'b0;
    @(negedge clk);
    bus_addr = addr; bus_wdata = wdata; bus_wstrb = wstrb; bus_valid = 1'b1;
    force_busy = (hold > 0);
    for (int k = 1; k <= 400 && !seen; k++) begin
      @(negedge clk);
      if (force_busy && (sd_rd_enable || sd_wr_enable)) en_forced++;
      if (first_en < 0 && (sd_rd_enable || sd_wr_enable)) first_en = k;
      if (k == hold) force_busy = 1'b0;
      if (bus_ready) begin
        pulses++;
        got_rdata = bus_rdata;
        seen = 1'b1;
        bus_valid = 1'b0;
      end
    end
    checkOutput("ready_seen", 64'(seen), 64'd1);
    force_busy = 1'b0;
    bus_valid  = 1'b0;
    for (int j = 0; j < 6; j++) begin
      @(negedge clk);
      if (bus_ready) pulses++;
    end
  endtask

  task automatic runOp(input string tag, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input int hold);
    modelOp(addr, wdata, wstrb);
    applyStimulus(addr, wdata, wstrb, hold);
    checkOutput({tag, "_pulses"}, 64'(pulses), 64'd1);
    checkOutput({tag, "_nacc"}, 64'(acc_q.size()), 64'(exp_q.size()));
    for (int i = 0; i < exp_q.size(); i++) checkOutput({tag, "_acc"}, 64'(accAt(i)), 64'(exp_q[i]));
    if (wstrb == 4'b0000) begin
      checkOutput({tag, "_rdata"}, 64'(got_rdata), 64'(exp_rdata));
      last_rdata = exp_rdata;
    end else begin
      checkOutput({tag, "_rdata_held"}, 64'(bus_rdata), 64'(last_rdata));
    end
    if (hold > 0) begin
      checkOutput({tag, "_en_while_busy"}, 64'(en_forced), 64'd0);
      checkOutput({tag, "_first_req"}, 64'(first_en >= hold + 1 && first_en <= hold + 2), 64'd1);
    end
  endtask

  initial begin
    bit found;
    logic [31:0] a, d;
    logic [3:0]  s;
    int          h;

    for (int i = 0; i < 1024; i++) preload(i, 16'($urandom));
    preload(8, 16'h1234);
    preload(9, 16'hABCD);

    repeat (4) @(negedge clk);
    resetn = 1'b1;
    @(negedge clk);
    checkOutput("rst_ready", 64'(bus_ready), 64'd0);
    checkOutput("rst_rdata", 64'(bus_rdata), 64'd0);
    checkOutput("rst_enables", 64'({sd_rd_enable, sd_wr_enable}), 64'd0);
    checkOutput("rst_addrs", 64'({sd_rd_addr, sd_wr_addr}), 64'd0);
    checkOutput("rst_wdata", 64'(sd_wr_data), 64'd0);

    $display("[TB] plan 1: two-beat read");
    runOp("t1", 32'h0400_0010, 32'h0, 4'b0000, 0);
    checkOutput("t1_word", 64'(got_rdata), 64'hABCD_1234);
    checkOutput("t1_rd0", 64'(accAt(0)), 64'(pack(1'b0, 22'h08, 16'h1234)));
    checkOutput("t1_rd1", 64'(accAt(1)), 64'(pack(1'b0, 22'h09, 16'hABCD)));

    $display("[TB] plan 2: full write");
    runOp("t2", 32'h0400_0020, 32'hDEAD_BEEF, 4'b1111, 0);
    checkOutput("t2_wr0", 64'(accAt(0)), 64'(pack(1'b1, 22'h10, 16'hBEEF)));
    checkOutput("t2_wr1", 64'(accAt(1)), 64'(pack(1'b1, 22'h11, 16'hDEAD)));

    $display("[TB] plan 3: upper-half write");
    runOp("t3", 32'h0400_0020, 32'hDEAD_BEEF, 4'b1100, 0);
    checkOutput("t3_count", 64'(acc_q.size()), 64'd1);
    checkOutput("t3_wr", 64'(accAt(0)), 64'(pack(1'b1, 22'h11, 16'hDEAD)));

    $display("[TB] plan 4: partial-lane write");
    preload(16, 16'h5566);
    runOp("t4", 32'h0400_0020, 32'hDEAD_BEEF, 4'b0010, 0);
    if (RMW_EN) begin
      checkOutput("t4_count", 64'(acc_q.size()), 64'd2);
      checkOutput("t4_rd", 64'(accAt(0)), 64'(pack(1'b0, 22'h10, 16'h5566)));
      checkOutput("t4_wr", 64'(accAt(1)), 64'(pack(1'b1, 22'h10, 16'hBE66)));
    end else begin
      checkOutput("t4_count", 64'(acc_q.size()), 64'd1);
      checkOutput("t4_wr", 64'(accAt(0)), 64'(pack(1'b1, 22'h10, 16'hBEEF)));
    end

    $display("[TB] plan 5: controller busy for 20 cycles");
    runOp("t5", 32'h0400_0100, 32'h0, 4'b0000, 20);

    $display("[TB] plan 6: reset during beat 1 of a read");
    acc_q.delete();
    found = 1'b0;
    @(negedge clk);
    bus_addr = 32'h0400_0010; bus_wstrb = 4'b0000; bus_valid = 1'b1;
    for (int k = 0; k < 200 && !found; k++) begin
      @(negedge clk);
      if (sd_rd_enable && sd_rd_addr == 22'h09) found = 1'b1;
    end
    checkOutput("t6_beat1", 64'(found), 64'd1);
    resetn = 1'b0;
    @(negedge clk);
    checkOutput("t6_enables", 64'({sd_rd_enable, sd_wr_enable}), 64'd0);
    checkOutput("t6_ready", 64'(bus_ready), 64'd0);
    checkOutput("t6_rdata", 64'(bus_rdata), 64'd0);
    bus_valid = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    last_rdata = '0;
    repeat (10) @(negedge clk);
    runOp("t6_rerun", 32'h0400_0010, 32'h0, 4'b0000, 0);
    checkOutput("t6_word", 64'(got_rdata), 64'hABCD_1234);

    $display("[TB] randomized operations");
    for (int n = 0; n < 30; n++) begin
      a = 32'h0400_0000 | (32'($urandom_range(0, 255)) << 2);
      d = $urandom;
      s = ($urandom_range(0, 2) == 0) ? 4'b0000 : 4'($urandom_range(1, 15));
      h = ($urandom_range(0, 4) == 0) ? $urandom_range(1, 6) : 0;
      runOp("rnd", a, d, s, h);
    end

    checkOutput("both_enables", 64'(both_cnt), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
